regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised two-read/one-write register file for the pipelined datapath, built as the successor to the 32x32 file.
- Reads are synchronous: registered on the rising edge, 1-cycle latency.
- Writes are on the same rising edge, with optional write-to-read bypass.
- An optional hardwired zero register is supported.
- A per-register pending-write scoreboard lets the hazard unit stall on registers whose producer has not yet written back.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never becomes busy
BYPASS, 1, 1: same-cycle write data forwarded to a matching read

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
readreg1  in  ADDR_W  read port 1 address
readreg2  in  ADDR_W  read port 2 address
read_data1  out  DATA_W  port 1 data, registered
read_data2  out  DATA_W  port 2 data, registered
read_busy1  out  1  port 1 register had pending write at sample time, registered
read_busy2  out  1  port 2 register had pending write at sample time, registered
regwrite  in  1  writeback enable
writereg  in  ADDR_W  writeback address
writedata  in  DATA_W  writeback data
issue  in  1  decode stage marks a destination as pending
issue_reg  in  ADDR_W  destination being issued
any_busy  out  1  OR of all scoreboard bits, registered

Behaviour:
- Reset (rst_n=0 at posedge):
  - All storage registers are cleared to 0.
  - All scoreboard bits are cleared.
  - read_data1/2, read_busy1/2 and any_busy go to 0.
  - regwrite and issue are ignored that cycle.
- Reset mid-operation discards pending scoreboard state. Storage contents are cleared as well; no preserve-on-reset mode exists.
- Write: at posedge with regwrite=1, reg[writereg] <= writedata.
  - ZERO_REG=1 and writereg=0: the write is dropped.
- Read: at posedge, read_data{n} <= value of reg[readreg{n}] as seen by the combined update, according to the first matching rule:
  - ZERO_REG=1 and readreg{n}=0: result is 0.
  - BYPASS=1, regwrite=1 and writereg==readreg{n}: result is writedata, i.e. new data visible with 1-cycle latency.
  - BYPASS=0: result is the old stored value; the new value is visible from the following read.
  - Otherwise: result is the stored value.
- Scoreboard: one bit per register, bit b[i].
  - issue=1: sets b[issue_reg].
  - regwrite=1: clears b[writereg].
  - Same cycle, same address for issue and regwrite: issue wins and the bit stays/becomes 1, because the newer producer is still outstanding.
  - Same cycle, different addresses: both updates apply.
  - ZERO_REG=1: b[0] is never set.
  - Re-issuing an already busy register keeps the bit at 1; there is no count, and a single writeback clears it.
  - Writeback to a non-busy register: data is written, the bit stays 0, and no error is raised.
- read_busy{n}: registered with the same timing as read_data{n}. It reflects the next-state bit, i.e. after this cycle's issue/regwrite updates.
  - Issue to X and read of X in the same cycle: read_busy=1.
  - Writeback to X and read of X in the same cycle without a same-cycle issue: read_busy=0.
- any_busy: registered OR of the next-state scoreboard bits.
- Both read ports may address the same register; both return identical data and busy.
- No X propagation: every output is defined from the first post-reset cycle.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then read regs 5 and 31 → read_data1=read_data2=0, read_busy=0, any_busy=0.
- Write 0xDEADBEEF to reg 7 while reading reg 7 on port 1 in the same cycle → BYPASS=1: read_data1=0xDEADBEEF next cycle. BYPASS=0: old value 0 that cycle, then 0xDEADBEEF on the following read.
- ZERO_REG=1: write 0x12345678 to reg 0, then read reg 0 on both ports → 0. issue with issue_reg=0 → any_busy stays 0.
- Issue reg 3, read reg 3 for 3 cycles, then writeback 0xA5A5A5A5 to reg 3 → read_busy1=1 for 3 cycles, then read_busy1=0 with read_data1=0xA5A5A5A5 in the writeback cycle's result, and any_busy falls to 0.
- Same-cycle issue of reg 9 and writeback of reg 9 with data 0x1 → reg 9 holds 0x1, b[9]=1, read_busy=1 on the next read. Same-cycle issue of reg 4 with writeback of reg 9 → b[4]=1, b[9]=0.
- Issue regs 2 and 6, assert rst_n=0 for one cycle → all busy bits 0, any_busy=0, and reads of regs 2 and 6 return 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Two-read / one-write register file with synchronous reads,
//            optional write-to-read bypass, optional hardwired zero register
//            and a per-register pending-write scoreboard for hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // read ports
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_busy1,
    output logic              read_busy2,
    // writeback port
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] writereg,
    input  logic [DATA_W-1:0] writedata,
    // issue port (marks a destination as pending)
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_reg,
    // scoreboard summary
    output logic              any_busy
);

    localparam int          c_depth     = 1 << ADDR_W;
    localparam logic        c_zero_en   = (ZERO_REG != 0);
    localparam logic        c_bypass_en = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] c_addr_zero = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [c_depth];
    logic [c_depth-1:0] r_sb;

    logic [DATA_W-1:0]  r_read_data1;
    logic [DATA_W-1:0]  r_read_data2;
    logic               r_read_busy1;
    logic               r_read_busy2;
    logic               r_any_busy;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_wr_en;      // write that actually lands in storage
    logic               w_zero_hit1;  // port 1 addresses the hardwired zero
    logic               w_zero_hit2;  // port 2 addresses the hardwired zero
    logic [c_depth-1:0] w_sb_next;
    logic [DATA_W-1:0]  w_rd_data1;
    logic [DATA_W-1:0]  w_rd_data2;

    // Zero-register decode exists only when the option is enabled; otherwise
    // register 0 behaves like any other entry.
    generate
        if (c_zero_en) begin : g_zero_reg
            assign w_zero_hit1 = (readreg1 == c_addr_zero);
            assign w_zero_hit2 = (readreg2 == c_addr_zero);
            assign w_wr_en     = regwrite && (writereg != c_addr_zero);
        end else begin : g_no_zero_reg
            assign w_zero_hit1 = 1'b0;
            assign w_zero_hit2 = 1'b0;
            assign w_wr_en     = regwrite;
        end
    endgenerate

    // Next-state scoreboard: writeback clears first, then issue sets, so a
    // same-address issue overrides the clear (the newer producer is still
    // outstanding). The zero register can never be marked busy.
    always_comb begin
        w_sb_next = r_sb;
        if (regwrite) begin
            w_sb_next[writereg] = 1'b0;
        end
        if (issue) begin
            w_sb_next[issue_reg] = 1'b1;
        end
        if (c_zero_en) begin
            w_sb_next[0] = 1'b0;
        end
    end

    // Port 1 read value: zero register, then same-cycle bypass, then storage.
    always_comb begin
        w_rd_data1 = r_mem[readreg1];
        if (w_zero_hit1) begin
            w_rd_data1 = '0;
        end else if (c_bypass_en && regwrite && (writereg == readreg1)) begin
            w_rd_data1 = writedata;
        end
    end

    // Port 2 read value: same priority as port 1.
    always_comb begin
        w_rd_data2 = r_mem[readreg2];
        if (w_zero_hit2) begin
            w_rd_data2 = '0;
        end else if (c_bypass_en && regwrite && (writereg == readreg2)) begin
            w_rd_data2 = writedata;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Register storage: cleared on reset, written on writeback (zero reg
    // writes are dropped by w_wr_en).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[writereg] <= writedata;
        end
    end

    // Scoreboard bits: reset discards all pending producers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    // Registered read results; busy flags reflect this cycle's updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_read_data1 <= '0;
            r_read_data2 <= '0;
            r_read_busy1 <= 1'b0;
            r_read_busy2 <= 1'b0;
            r_any_busy   <= 1'b0;
        end else begin
            r_read_data1 <= w_rd_data1;
            r_read_data2 <= w_rd_data2;
            r_read_busy1 <= w_sb_next[readreg1];
            r_read_busy2 <= w_sb_next[readreg2];
            r_any_busy   <= |w_sb_next;
        end
    end

    assign read_data1 = r_read_data1;
    assign read_data2 = r_read_data2;
    assign read_busy1 = r_read_busy1;
    assign read_busy2 = r_read_busy2;
    assign any_busy   = r_any_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed, table-driven self-checking bench for regfile_scoreboard
//            (DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  readreg1;
    logic [4:0]  readreg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        read_busy1;
    logic        read_busy2;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        issue;
    logic [4:0]  issue_reg;
    logic        any_busy;

    int checks;
    int errors;

    typedef struct {
        logic        rst_n;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ir;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_any;
    } vec_t;

    vec_t vecs[$];

    regfile_scoreboard #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .ZERO_REG(1),
        .BYPASS  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .readreg1  (readreg1),
        .readreg2  (readreg2),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .read_busy1(read_busy1),
        .read_busy2(read_busy2),
        .regwrite  (regwrite),
        .writereg  (writereg),
        .writedata (writedata),
        .issue     (issue),
        .issue_reg (issue_reg),
        .any_busy  (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rn, input logic [4:0] rr1, input logic [4:0] rr2,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic iss, input logic [4:0] ir,
                       input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                       input logic e_b1, input logic e_b2, input logic e_any);
        vec_t v;
        v.rst_n = rn;  v.rr1 = rr1; v.rr2 = rr2;
        v.we = we;     v.wr = wr;   v.wd = wd;
        v.iss = iss;   v.ir = ir;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2;
        v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_any = e_any;
        vecs.push_back(v);
    endtask

    // Drive one set of inputs, let one rising edge happen, sample 1ns after.
    task automatic step(input logic rn, input logic [4:0] rr1, input logic [4:0] rr2,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic iss, input logic [4:0] ir);
        @(negedge clk);
        rst_n = rn; readreg1 = rr1; readreg2 = rr2;
        regwrite = we; writereg = wr; writedata = wd;
        issue = iss; issue_reg = ir;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; readreg1 = '0; readreg2 = '0;
        regwrite = 1'b0; writereg = '0; writedata = '0;
        issue = 1'b0; issue_reg = '0;

        //  rst  rr1 rr2  we wr  wd            iss ir   e_rd1         e_rd2         b1 b2 any
        // reset for two cycles; write/issue during reset are ignored
        add(0,   0,  0,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
        add(0,   0,  0,   1, 7,  32'hFF,       1,  3,   32'h0,        32'h0,        0, 0, 0);
        add(1,   5, 31,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
        // bypass of a same-cycle write, then plain read of stored value
        add(1,   7,  5,   1, 7,  32'hDEADBEEF, 0,  0,   32'hDEADBEEF, 32'h0,        0, 0, 0);
        add(1,   7,  7,   0, 0,  32'h0,        0,  0,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        // zero register: write dropped, issue ignored
        add(1,   0,  0,   1, 0,  32'h12345678, 0,  0,   32'h0,        32'h0,        0, 0, 0);
        add(1,   0,  0,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
        add(1,   0,  0,   0, 0,  32'h0,        1,  0,   32'h0,        32'h0,        0, 0, 0);
        // issue reg 3, busy for three reads, then writeback clears
        add(1,   3,  7,   0, 0,  32'h0,        1,  3,   32'h0,        32'hDEADBEEF, 1, 0, 1);
        add(1,   3,  3,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        1, 1, 1);
        add(1,   3,  3,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        1, 1, 1);
        add(1,   3,  3,   1, 3,  32'hA5A5A5A5, 0,  0,   32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0);
        // same-cycle issue+writeback to reg 9: issue wins
        add(1,   9,  3,   1, 9,  32'h1,        1,  9,   32'h1,        32'hA5A5A5A5, 1, 0, 1);
        add(1,   9,  9,   0, 0,  32'h0,        0,  0,   32'h1,        32'h1,        1, 1, 1);
        // issue 4 with writeback to 9: both apply
        add(1,   4,  9,   1, 9,  32'h22,       1,  4,   32'h0,        32'h22,       1, 0, 1);
        add(1,   4,  9,   0, 0,  32'h0,        0,  0,   32'h0,        32'h22,       1, 0, 1);
        // re-issue of busy reg 4, single writeback clears it
        add(1,   4,  4,   0, 0,  32'h0,        1,  4,   32'h0,        32'h0,        1, 1, 1);
        add(1,   4,  4,   1, 4,  32'h44,       0,  0,   32'h44,       32'h44,       0, 0, 0);
        // writeback to a non-busy register
        add(1,  10, 10,   1, 10, 32'hABCD,     0,  0,   32'hABCD,     32'hABCD,     0, 0, 0);
        // issue 2 and 6, then reset mid-operation
        add(1,   2,  6,   0, 0,  32'h0,        1,  2,   32'h0,        32'h0,        1, 0, 1);
        add(1,   2,  6,   0, 0,  32'h0,        1,  6,   32'h0,        32'h0,        1, 1, 1);
        add(0,   2,  6,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
        add(1,   2,  6,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
        // storage was cleared by the reset
        add(1,   7,  3,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
        add(1,   9, 10,   0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
        // bypass on port 2 only
        add(1,  30, 31,   1, 31, 32'hCAFEF00D, 0,  0,   32'h0,        32'hCAFEF00D, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].rr1, vecs[i].rr2, vecs[i].we, vecs[i].wr,
                 vecs[i].wd, vecs[i].iss, vecs[i].ir);
            check($sformatf("v%0d read_data1", i), read_data1, vecs[i].e_rd1);
            check($sformatf("v%0d read_data2", i), read_data2, vecs[i].e_rd2);
            check($sformatf("v%0d read_busy1", i), {31'b0, read_busy1}, {31'b0, vecs[i].e_b1});
            check($sformatf("v%0d read_busy2", i), {31'b0, read_busy2}, {31'b0, vecs[i].e_b2});
            check($sformatf("v%0d any_busy", i),   {31'b0, any_busy},   {31'b0, vecs[i].e_any});
        end

        // Sequence: mark every register 1..31 pending, then retire them in
        // order; any_busy must stay high until the very last writeback.
        for (int r = 1; r < 32; r++) begin
            step(1'b1, 5'(r), 5'(r), 1'b0, 5'd0, 32'h0, 1'b1, 5'(r));
            check($sformatf("seq issue r%0d busy1", r), {31'b0, read_busy1}, 32'd1);
            check($sformatf("seq issue r%0d any", r),   {31'b0, any_busy},   32'd1);
        end
        for (int r = 1; r < 32; r++) begin
            step(1'b1, 5'(r), 5'(r == 31 ? 1 : r + 1), 1'b1, 5'(r), 32'h100 + 32'(r), 1'b0, 5'd0);
            check($sformatf("seq wb r%0d data1", r), read_data1, 32'h100 + 32'(r));
            check($sformatf("seq wb r%0d busy1", r), {31'b0, read_busy1}, 32'd0);
            check($sformatf("seq wb r%0d busy2", r), {31'b0, read_busy2}, (r == 31) ? 32'd0 : 32'd1);
            check($sformatf("seq wb r%0d any", r),   {31'b0, any_busy},   (r == 31) ? 32'd0 : 32'd1);
        end

        // Sequence: retained data after the sweep, read back on both ports.
        step(1'b1, 5'd17, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        check("seq hold data1", read_data1, 32'h111);
        check("seq hold data2", read_data2, 32'h11F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
